// File: rtl/ram8_burst_master_pkg.sv
// Shared definitions for the ram8 burst master: FSM state encodings and RAM geometry.
// Benches that talk to the ram8 port import the same geometry constants.
package ram8_burst_master_pkg;

  localparam int RAM_DW = 16;
  localparam int RAM_AW = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR       = 2'd1,
    ST_RD       = 2'd2,
    ST_RD_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram8_burst_master.sv
// Burst initiator for the 8 x 16 RAM port: takes one command at a time and runs a
// wrapping write or read burst, with a valid/ready write stream and a registered read stream.
module ram8_burst_master
  import ram8_burst_master_pkg::*;
#(
  parameter int DW = RAM_DW,
  parameter int AW = RAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] wdata,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic          busy,
  output logic          done,
  output logic          ram_en,
  output logic          ram_w,
  output logic          ram_r,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] cnt;
  logic          issue;
  logic          accept_cmd;
  logic          advance;
  logic          finish;
  logic          read_fire;

  // A read may be issued whenever the output register is empty or being drained this cycle.
  assign issue     = !rdata_valid || rdata_ready;
  assign read_fire = (state == ST_RD) && issue;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // RAM pins decode purely from state so a reset immediately releases the port.
  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    ram_en      = 1'b0;
    ram_w       = 1'b0;
    ram_r       = 1'b0;
    ram_add     = '0;
    ram_din     = '0;
    accept_cmd  = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept_cmd = 1'b1;
          state_next = cmd_write ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        wdata_ready = 1'b1;
        ram_en      = 1'b1;
        ram_add     = ptr;
        ram_din     = wdata;
        ram_w       = wdata_valid;
        if (wdata_valid) begin
          advance = 1'b1;
          if (cnt == '0) begin
            state_next = ST_IDLE;
            finish     = 1'b1;
          end
        end
      end
      ST_RD: begin
        ram_en  = 1'b1;
        ram_add = ptr;
        ram_r   = issue;
        if (issue) begin
          advance = 1'b1;
          if (cnt == '0) begin
            state_next = ST_RD_DRAIN;
          end
        end
      end
      ST_RD_DRAIN: begin
        if (rdata_valid && rdata_ready) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ptr wraps naturally at 2**AW; cnt holds words remaining minus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (accept_cmd) begin
      ptr <= cmd_addr;
      cnt <= cmd_len;
    end else if (advance) begin
      ptr <= ptr + 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else if (read_fire) begin
      rdata       <= ram_dout;
      rdata_valid <= 1'b1;
    end else if (rdata_valid && rdata_ready) begin
      rdata_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= finish;
    end
  end

endmodule

// File: tb/tb_ram8_burst_master.sv
// Directed bench for ram8_burst_master with a behavioural 8 x 16 RAM on the ram_* port.
module tb_ram8_burst_master;
  import ram8_burst_master_pkg::*;

  localparam int DW = RAM_DW;
  localparam int AW = RAM_AW;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] wdata;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          rdata_ready;
  logic          busy;
  logic          done;
  logic          ram_en;
  logic          ram_w;
  logic          ram_r;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] got [$];
  logic [DW-1:0] before4;
  logic [3:0]    gapValid;
  int            compareCount;
  int            mismatchCount;
  int            wPulses;
  logic          doneSeen;

  ram8_burst_master #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .busy(busy), .done(done),
    .ram_en(ram_en), .ram_w(ram_w), .ram_r(ram_r),
    .ram_add(ram_add), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: synchronous write, combinational read; a poison value stands in for a floating bus.
  always @(posedge clk) begin
    if (ram_en && ram_w) mem[ram_add] <= ram_din;
  end
  assign ram_dout = (ram_en && ram_r) ? mem[ram_add] : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic cv, input logic cw, input logic [AW-1:0] ca,
                               input logic [AW-1:0] cl, input logic [DW-1:0] wd,
                               input logic wv, input logic rr);
    cmd_valid   = cv;
    cmd_write   = cw;
    cmd_addr    = ca;
    cmd_len     = cl;
    wdata       = wd;
    wdata_valid = wv;
    rdata_ready = rr;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);

    // Reset state
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_rvalid", 32'(rdata_valid), 0);
    checkOutput("rst_rdata", 32'(rdata), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_ram_en", 32'(ram_en), 0);
    checkOutput("rst_ram_w", 32'(ram_w), 0);
    checkOutput("rst_ram_r", 32'(ram_r), 0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;

    // Write burst 5,6,7,0 with wrap
    applyStimulus(1'b1, 1'b1, 3'd5, 3'd3, 16'h0, 1'b0, 1'b0);
    checkOutput("wr_cmd_ready", 32'(cmd_ready), 1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, DW'(16'hA001 + i), 1'b1, 1'b0);
      checkOutput("wr_ram_w", 32'(ram_w), 1);
      checkOutput("wr_ram_add", 32'(ram_add), (5 + i) % 8);
      checkOutput("wr_busy", 32'(busy), 1);
      checkOutput("wr_cmd_ready", 32'(cmd_ready), 0);
      checkOutput("wr_wready", 32'(wdata_ready), 1);
      checkOutput("wr_done_early", 32'(done), 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("wr_done", 32'(done), 1);
    checkOutput("wr_busy_end", 32'(busy), 0);
    nextCycle();
    checkOutput("wr_done_pulse", 32'(done), 0);
    checkOutput("wr_mem5", 32'(mem[5]), 'hA001);
    checkOutput("wr_mem6", 32'(mem[6]), 'hA002);
    checkOutput("wr_mem7", 32'(mem[7]), 'hA003);
    checkOutput("wr_mem0", 32'(mem[0]), 'hA004);

    // Read burst with rdata_ready held high
    applyStimulus(1'b1, 1'b0, 3'd5, 3'd3, 16'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("rd_ram_r0", 32'(ram_r), 1);
    checkOutput("rd_ram_add0", 32'(ram_add), 5);
    checkOutput("rd_rvalid0", 32'(rdata_valid), 0);
    checkOutput("rd_ram_w", 32'(ram_w), 0);
    nextCycle();
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1);
      checkOutput("rd_rvalid", 32'(rdata_valid), 1);
      checkOutput("rd_rdata", 32'(rdata), 'hA000 + k);
      checkOutput("rd_ram_r", 32'(ram_r), 1);
      checkOutput("rd_ram_add", 32'(ram_add), (5 + k) % 8);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("rd_drain_rvalid", 32'(rdata_valid), 1);
    checkOutput("rd_drain_rdata", 32'(rdata), 'hA004);
    checkOutput("rd_drain_ram_en", 32'(ram_en), 0);
    checkOutput("rd_drain_busy", 32'(busy), 1);
    checkOutput("rd_drain_done", 32'(done), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("rd_done", 32'(done), 1);
    checkOutput("rd_rvalid_end", 32'(rdata_valid), 0);
    checkOutput("rd_busy_end", 32'(busy), 0);
    nextCycle();

    // Read with backpressure on cycles 1..3
    applyStimulus(1'b1, 1'b0, 3'd5, 3'd3, 16'h0, 1'b0, 1'b1);
    nextCycle();
    doneSeen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, (c >= 1 && c <= 3) ? 1'b0 : 1'b1);
      if (c >= 1 && c <= 3) begin
        checkOutput("bp_ram_r", 32'(ram_r), 0);
        checkOutput("bp_hold_rdata", 32'(rdata), 'hA001);
        checkOutput("bp_hold_rvalid", 32'(rdata_valid), 1);
      end
      if (rdata_valid && rdata_ready) got.push_back(rdata);
      nextCycle();
      if (done) begin
        doneSeen = 1'b1;
        break;
      end
    end
    checkOutput("bp_done", 32'(doneSeen), 1);
    checkOutput("bp_count", 32'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checkOutput("bp_word", 32'(got[i]), 'hA001 + i);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
    nextCycle();

    // Write with gaps in wdata_valid: 1,0,0,1
    before4  = mem[4];
    gapValid = 4'b1001;
    wPulses  = 0;
    applyStimulus(1'b1, 1'b1, 3'd2, 3'd1, 16'h0, 1'b0, 1'b0);
    nextCycle();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0,
                    (c == 0) ? 16'hB001 : (c == 3) ? 16'hB002 : DW'(16'hBAD0 + c),
                    gapValid[c], 1'b0);
      checkOutput("gap_ram_w", 32'(ram_w), 32'(gapValid[c]));
      if (ram_w) wPulses++;
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("gap_done", 32'(done), 1);
    checkOutput("gap_pulses", 32'(wPulses), 2);
    checkOutput("gap_mem2", 32'(mem[2]), 'hB001);
    checkOutput("gap_mem3", 32'(mem[3]), 'hB002);
    checkOutput("gap_mem4", 32'(mem[4]), 32'(before4));
    nextCycle();

    // Reset during the second word of an 8-word read
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd7, 16'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("mid_rvalid_pre", 32'(rdata_valid), 1);
    checkOutput("mid_ram_r_pre", 32'(ram_r), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rvalid", 32'(rdata_valid), 0);
    checkOutput("mid_ram_en", 32'(ram_en), 0);
    checkOutput("mid_ram_r", 32'(ram_r), 0);
    checkOutput("mid_busy", 32'(busy), 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("mid_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("mid_busy_after", 32'(busy), 0);
    nextCycle();

    // Command held valid during a write burst
    applyStimulus(1'b1, 1'b1, 3'd3, 3'd1, 16'h0, 1'b0, 1'b1);
    nextCycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b0, 3'd3, 3'd0, DW'(16'hC001 + c), 1'b1, 1'b1);
      checkOutput("cwb_cmd_ready", 32'(cmd_ready), 0);
      checkOutput("cwb_busy", 32'(busy), 1);
      checkOutput("cwb_wready", 32'(wdata_ready), 1);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 3'd3, 3'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("cwb_done", 32'(done), 1);
    checkOutput("cwb_idle_ready", 32'(cmd_ready), 1);
    checkOutput("cwb_idle_busy", 32'(busy), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("cwb_rd_busy", 32'(busy), 1);
    checkOutput("cwb_rd_ram_r", 32'(ram_r), 1);
    checkOutput("cwb_rd_add", 32'(ram_add), 3);
    nextCycle();
    checkOutput("cwb_rvalid", 32'(rdata_valid), 1);
    checkOutput("cwb_rdata", 32'(rdata), 'hC001);
    nextCycle();
    checkOutput("cwb_rd_done", 32'(done), 1);
    checkOutput("cwb_mem4", 32'(mem[4]), 'hC002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
